mister_sd_sector: RTL and testbench

Core-side initiator for one MiSTer virtual block device: accepts single-sector read/write commands from the SCSI disk emulation in `ss_core` and runs the `sd_rd`/`sd_wr`/`sd_ack` handshake toward `hps_io`. It owns a 512-byte sector buffer holding 256 x 16-bit words, shared between the client port and the HPS buffer bus. It also tracks image mount state and size. There is one instance per drive slot (HD, HD2, CDROM).

---
 rtl/mister_sd_sector.sv | 164 ++++++++++++++++
 tb/tb_mister_sd_sector.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mister_sd_sector.sv
// mister_sd_sector
// Core-side initiator for one MiSTer virtual block device. Accepts single
// sector read/write commands from the disk emulation and runs the
// sd_rd/sd_wr/sd_ack handshake toward hps_io. Owns a 256 x 16-bit sector
// buffer shared by the client port (A) and the HPS buffer bus (B), and
// tracks image mount state and size.
//
// Ports:
//   clk, reset_na            system clock, async active-low reset
//   img_mounted/readonly/size mount pulse and image attributes
//   sd_lba, sd_rd, sd_wr     request toward HPS
//   sd_ack                   HPS transfer-in-progress level
//   sd_buff_addr/dout/din/wr HPS buffer bus (port B)
//   mounted, ro, nsect       mount status, size in sectors (saturated)
//   cmd_req/wr/lba           client command strobe, direction, sector
//   busy, done, err          command status
//   buf_addr/wdata/we/rdata  client buffer port (port A), 1-cycle read
module mister_sd_sector #(
  parameter int unsigned TIMEOUT = 32'd16777216
) (
  input  logic        clk,
  input  logic        reset_na,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [15:0] sd_buff_dout,
  output logic [15:0] sd_buff_din,
  input  logic        sd_buff_wr,
  output logic        mounted,
  output logic        ro,
  output logic [31:0] nsect,
  input  logic        cmd_req,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_lba,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic [7:0]  buf_addr,
  input  logic [15:0] buf_wdata,
  input  logic        buf_we,
  output logic [15:0] buf_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER,
    S_DONE
  } state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_t      state;
  logic        wr_q;
  logic [31:0] to_cnt;

  logic [15:0] mem [256];
  logic        a_we;
  logic        b_we;

  assign busy = (state != S_IDLE);
  assign a_we = buf_we && (state == S_IDLE);
  assign b_we = sd_buff_wr && (state == S_XFER) && !wr_q;

  // Command sequencer
  always_ff @(posedge clk or negedge reset_na) begin
    if (!reset_na) begin
      state  <= S_IDLE;
      wr_q   <= 1'b0;
      to_cnt <= '0;
      sd_lba <= '0;
      sd_rd  <= 1'b0;
      sd_wr  <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_req) begin
            wr_q   <= cmd_wr;
            sd_lba <= cmd_lba;
            to_cnt <= '0;
            if (!mounted || (cmd_wr && ro)) begin
              // Refused without ever touching the HPS handshake
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              err   <= 1'b0;
              sd_rd <= !cmd_wr;
              sd_wr <= cmd_wr;
              state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (sd_ack) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= S_XFER;
          end else if (to_cnt == TO_LAST) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            err   <= 1'b1;
            state <= S_DONE;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        S_XFER: begin
          if (!sd_ack) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Mount tracking; independent of any command in flight
  always_ff @(posedge clk or negedge reset_na) begin
    if (!reset_na) begin
      mounted <= 1'b0;
      ro      <= 1'b0;
      nsect   <= '0;
    end else if (img_mounted) begin
      mounted <= (img_size != 64'd0);
      ro      <= img_readonly;
      nsect   <= (|img_size[63:41]) ? '1 : img_size[40:9];
    end
  end

  // Sector buffer storage. The two write enables are mutually exclusive
  // by state (IDLE vs XFER), so no same-address write collision exists.
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem[buf_addr] <= buf_wdata;
    end
    if (b_we) begin
      mem[sd_buff_addr] <= sd_buff_dout;
    end
  end

  // Registered read ports, active in every state
  always_ff @(posedge clk or negedge reset_na) begin
    if (!reset_na) begin
      buf_rdata   <= '0;
      sd_buff_din <= '0;
    end else begin
      buf_rdata   <= mem[buf_addr];
      sd_buff_din <= mem[sd_buff_addr];
    end
  end

endmodule

// File: tb/tb_mister_sd_sector.sv
module tb_mister_sd_sector;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        reset_na = 1'b1;
  logic        img_mounted = 1'b0;
  logic        img_readonly = 1'b0;
  logic [63:0] img_size = '0;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack = 1'b0;
  logic [7:0]  sd_buff_addr = '0;
  logic [15:0] sd_buff_dout = '0;
  logic [15:0] sd_buff_din;
  logic        sd_buff_wr = 1'b0;
  logic        mounted;
  logic        ro;
  logic [31:0] nsect;
  logic        cmd_req = 1'b0;
  logic        cmd_wr = 1'b0;
  logic [31:0] cmd_lba = '0;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  buf_addr = '0;
  logic [15:0] buf_wdata = '0;
  logic        buf_we = 1'b0;
  logic [15:0] buf_rdata;

  always #5 clk = ~clk;

  mister_sd_sector #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_na(reset_na),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
    .mounted(mounted), .ro(ro), .nsect(nsect),
    .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_lba(cmd_lba),
    .busy(busy), .done(done), .err(err),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(buf_we),
    .buf_rdata(buf_rdata)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model state
  logic [15:0] ref_mem [256];
  bit          ref_mounted = 0;
  bit          ref_ro = 0;
  logic [31:0] ref_nsect = '0;
  bit          saw_rd, saw_wr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (sd_rd) saw_rd = 1;
    if (sd_wr) saw_wr = 1;
  endtask

  function automatic logic [31:0] size_to_sect(input logic [63:0] size);
    if (size >= 64'h0000_0200_0000_0000) return 32'hFFFF_FFFF;
    return 32'(size / 64'd512);
  endfunction

  task automatic mount(input logic [63:0] size, input bit rdonly);
    img_size = size;
    img_readonly = rdonly;
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
    img_readonly = 1'($urandom);
    ref_mounted = (size != 64'd0);
    ref_ro = rdonly;
    ref_nsect = size_to_sect(size);
    chk("mounted", mounted, ref_mounted);
    chk("ro", ro, ref_ro);
    chk("nsect", nsect, ref_nsect);
  endtask

  task automatic client_fill(input bit rnd);
    for (int a = 0; a < 256; a++) begin
      buf_addr = 8'(a);
      buf_wdata = rnd ? 16'($urandom) : ~16'(a);
      buf_we = 1'b1;
      tick();
      ref_mem[a] = buf_wdata;
    end
    buf_we = 1'b0;
  endtask

  task automatic client_dump();
    for (int a = 0; a < 256; a++) begin
      buf_addr = 8'(a);
      tick();
      chk($sformatf("buf_rdata[%0d]", a), buf_rdata, ref_mem[a]);
    end
  endtask

  // ack_dly < 0: HPS never acknowledges
  task automatic do_cmd(input bit wr, input logic [31:0] lba, input int ack_dly,
                        input bit rnd_data, input bit collide, input bit mid_mount);
    bit exp_ref;
    int hi;
    logic [15:0] w;
    exp_ref = !ref_mounted || (wr && ref_ro);
    saw_rd = 0;
    saw_wr = 0;
    cmd_req = 1'b1;
    cmd_wr = wr;
    cmd_lba = lba;
    tick();
    cmd_req = 1'b0;
    cmd_wr = 1'($urandom);
    cmd_lba = $urandom;
    chk("busy_accept", busy, 1);
    chk("sd_lba", sd_lba, lba);
    if (exp_ref) begin
      chk("req_refused", {sd_rd, sd_wr}, 0);
      chk("done_early", done, 0);
      tick();
      chk("done_refused", done, 1);
      chk("err_refused", err, 1);
      chk("busy_refused", busy, 0);
      chk("no_req", {saw_rd, saw_wr}, 0);
      tick();
      chk("done_pulse", done, 0);
      chk("err_hold", err, 1);
      return;
    end
    chk("req_level", {sd_rd, sd_wr}, wr ? 2'b01 : 2'b10);
    hi = 1;
    if (ack_dly < 0) begin
      for (int k = 0; k < 200; k++) begin
        tick();
        if (sd_rd || sd_wr) hi++;
        else break;
      end
      chk("timeout_cycles", hi, TO);
      chk("done_before_timeout", done, 0);
      tick();
      chk("done_timeout", done, 1);
      chk("err_timeout", err, 1);
    end else begin
      repeat (ack_dly) begin
        tick();
        if (sd_rd || sd_wr) hi++;
      end
      sd_ack = 1'b1;
      tick();
      chk("req_cycles", hi, ack_dly + 1);
      chk("req_drop", {sd_rd, sd_wr}, 0);
      for (int a = 0; a < 256; a++) begin
        sd_buff_addr = 8'(a);
        if (!wr) begin
          w = rnd_data ? 16'($urandom) : 16'hA500 + 16'(a);
          sd_buff_dout = w;
          sd_buff_wr = 1'b1;
        end else if (collide) begin
          sd_buff_dout = 16'($urandom);
          sd_buff_wr = 1'($urandom);
        end
        if (collide && a == 77) begin
          cmd_req = 1'b1;
          cmd_wr = 1'($urandom);
          cmd_lba = $urandom;
          buf_we = 1'b1;
          buf_addr = 8'($urandom);
          buf_wdata = 16'($urandom);
        end
        if (mid_mount && a == 128) begin
          img_size = 64'h1234_5600;
          img_readonly = 1'b1;
          img_mounted = 1'b1;
        end
        tick();
        cmd_req = 1'b0;
        buf_we = 1'b0;
        if (!wr) ref_mem[a] = w;
        else chk($sformatf("hps_din[%0d]", a), sd_buff_din, ref_mem[a]);
        if (mid_mount && a == 128) begin
          img_mounted = 1'b0;
          ref_mounted = 1;
          ref_ro = 1;
          ref_nsect = size_to_sect(64'h1234_5600);
          chk("mid_mount_ro", ro, 1);
          chk("mid_mount_busy", busy, 1);
        end
      end
      sd_buff_wr = 1'b0;
      sd_ack = 1'b0;
      tick();
      chk("done_xfer_early", done, 0);
      chk("busy_xfer", busy, 1);
      tick();
      chk("done_xfer", done, 1);
      chk("err_xfer", err, 0);
      chk("busy_after", busy, 0);
    end
    chk("lba_hold", sd_lba, lba);
    chk("other_req", wr ? saw_rd : saw_wr, 0);
    tick();
    chk("done_pulse", done, 0);
  endtask

  task automatic reset_mid(input bit in_xfer);
    mount(64'h10_0000, 0);
    cmd_req = 1'b1;
    cmd_wr = 1'b0;
    cmd_lba = 32'h42;
    tick();
    cmd_req = 1'b0;
    chk("rst_pre_rd", sd_rd, 1);
    if (in_xfer) begin
      sd_ack = 1'b1;
      tick();
      sd_buff_wr = 1'b1;
      tick();
      tick();
      chk("rst_pre_busy", busy, 1);
    end
    #2;
    reset_na = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req", {sd_rd, sd_wr}, 0);
    chk("rst_mounted", mounted, 0);
    chk("rst_err", err, 0);
    chk("rst_nsect", nsect, 0);
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    tick();
    tick();
    reset_na = 1'b1;
    ref_mounted = 0;
    ref_ro = 0;
    ref_nsect = '0;
    tick();
    chk("rst_idle_busy", busy, 0);
  endtask

  initial begin
    #5_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1);
  end

  initial begin
    #3 reset_na = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_req", {sd_rd, sd_wr}, 0);
    chk("reset_done_err", {done, err}, 0);
    chk("reset_mount", {mounted, ro}, 0);
    chk("reset_nsect", nsect, 0);
    chk("reset_lba", sd_lba, 0);
    chk("reset_rdata", {sd_buff_din, buf_rdata}, 0);
    reset_na = 1'b1;
    tick();

    do_cmd(0, 32'd9, 5, 0, 0, 0);                // no image: refused
    mount(64'h1_0000_0000, 0);
    chk("nsect_4g", nsect, 32'h0080_0000);
    client_fill(1);
    do_cmd(0, 32'd5, 10, 0, 1, 0);               // read, HPS acks after 10
    buf_addr = 8'h7F;
    tick();
    chk("rd_7f", buf_rdata, 16'hA57F);
    client_dump();
    client_fill(0);
    do_cmd(1, 32'hFFFF_FFFE, 3, 0, 1, 0);        // write ~addr to HPS
    client_dump();
    do_cmd(0, 32'd1, -1, 0, 0, 0);               // read timeout
    do_cmd(1, 32'd2, -1, 0, 0, 0);               // write timeout
    do_cmd(0, 32'd7, 0, 1, 0, 1);                // mount pulse mid-read
    client_dump();
    do_cmd(1, 32'd8, 2, 0, 0, 0);                // write to read-only: refused
    mount(64'd0, 0);
    do_cmd(0, 32'd3, 1, 0, 0, 0);                // unmounted: refused
    mount(64'h0000_01FF_FFFF_FFFF, 0);
    mount(64'h0000_0200_0000_0000, 0);
    mount(64'd511, 0);
    do_cmd(0, 32'd4, 0, 1, 0, 0);                // 511-byte image still mounted

    for (int it = 0; it < 24; it++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op <= 1) begin
        logic [63:0] sz;
        case ($urandom_range(0, 5))
          0: sz = 64'd0;
          1: sz = 64'($urandom_range(1, 511));
          2: sz = {32'h0, $urandom};
          3: sz = {$urandom, $urandom};
          4: sz = 64'h0000_01FF_FFFF_FFFF;
          default: sz = {23'h0, 9'($urandom), $urandom};
        endcase
        mount(sz, ($urandom_range(0, 3) == 0));
      end else if (op == 2) begin
        client_fill(1);
      end else if (op == 3) begin
        client_dump();
      end else begin
        int dly;
        dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 20));
        do_cmd(1'($urandom), $urandom, dly, 1, 1'($urandom), 0);
      end
    end
    client_dump();

    reset_mid(0);
    reset_mid(1);
    client_fill(1);
    mount(64'h8000, 0);
    do_cmd(0, 32'd11, 4, 1, 0, 0);
    client_dump();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
